// File: rtl/axi4_mem_tester.sv
// AXI4 memory tester: writes NUM_BURSTS 16-beat INCR bursts of (address ^ seed), then reads them
// back and counts mismatches, bad read responses and bad write responses.
module axi4_mem_tester #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] err_addr_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o
);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

  localparam logic [15:0] LastBurst = 16'(NUM_BURSTS - 1);

  state_e      state_q;
  logic [31:0] seed_q;
  logic [15:0] burst_q;
  logic [3:0]  beat_q;
  logic [15:0] err_count_q;
  logic [31:0] err_addr_q;
  logic        busy_q, done_q, pass_q;
  logic        awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [31:0] awaddr_q, wdata_q, araddr_q;

  logic [31:0] burst_addr, next_burst_addr, beat_addr, next_beat_addr, rd_expect;
  logic [31:0] err_hit_addr;
  logic        last_burst, b_err, r_err, err_hit;

  always_comb begin
    burst_addr      = BASE_ADDR + {10'd0, burst_q, 6'd0};
    next_burst_addr = burst_addr + 32'd64;
    beat_addr       = burst_addr + {26'd0, beat_q, 2'b00};
    next_beat_addr  = beat_addr + 32'd4;
    rd_expect       = beat_addr ^ seed_q;
    last_burst      = (burst_q == LastBurst);
    b_err           = (state_q == StB) && axi_bvalid_i && (axi_bresp_i != 2'b00);
    r_err           = (state_q == StR) && axi_rvalid_i &&
                      ((axi_rdata_i != rd_expect) || (axi_rresp_i != 2'b00));
    err_hit         = b_err | r_err;
    err_hit_addr    = b_err ? burst_addr : beat_addr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Only the first error of a pass records its address; the count saturates.
      if (err_hit) begin
        if (err_count_q == 16'h0000) err_addr_q <= err_hit_addr;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end

      case (state_q)
        StIdle: begin
          if (start_i) begin
            seed_q      <= seed_i;
            burst_q     <= '0;
            beat_q      <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            awvalid_q   <= 1'b1;
            awaddr_q    <= BASE_ADDR;
            state_q     <= StAw;
          end
        end
        StAw: begin
          if (axi_awready_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= burst_addr ^ seed_q;
            wlast_q   <= 1'b0;
            beat_q    <= '0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (axi_wready_i) begin
            if (beat_q == 4'd15) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              beat_q  <= beat_q + 4'd1;
              wdata_q <= next_beat_addr ^ seed_q;
              wlast_q <= (beat_q == 4'd14);
            end
          end
        end
        StB: begin
          if (axi_bvalid_i) begin
            bready_q <= 1'b0;
            if (last_burst) begin
              burst_q   <= '0;
              arvalid_q <= 1'b1;
              araddr_q  <= BASE_ADDR;
              state_q   <= StAr;
            end else begin
              burst_q   <= burst_q + 16'd1;
              awvalid_q <= 1'b1;
              awaddr_q  <= next_burst_addr;
              state_q   <= StAw;
            end
          end
        end
        StAr: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (axi_rvalid_i) begin
            beat_q <= beat_q + 4'd1;
            if (axi_rlast_i) begin
              rready_q <= 1'b0;
              if (last_burst) begin
                busy_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                burst_q   <= burst_q + 16'd1;
                arvalid_q <= 1'b1;
                araddr_q  <= next_burst_addr;
                state_q   <= StAr;
              end
            end
          end
        end
        StDone: begin
          // The final read beat's error has landed in err_count_q by now.
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 16'h0000);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_count_o   = err_count_q;
  assign err_addr_o    = err_addr_q;
  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = awaddr_q;
  assign axi_awlen_o   = 8'd15;
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = 4'hF;
  assign axi_wlast_o   = wlast_q;
  assign axi_bready_o  = bready_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = 8'd15;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi4_mem_tester.sv
// Bench for axi4_mem_tester: reactive AXI slave with a sparse memory, optional stalls and
// fault injection, checked against a burst/beat-level model of the expected outcome.
module tb_axi4_mem_tester;

  localparam int NB = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] NO_FLIP = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi4_mem_tester #(.BASE_ADDR(BASE), .NUM_BURSTS(NB)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count), .err_addr_o(err_addr),
    .axi_awvalid_o(awvalid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
    .axi_awburst_o(awburst), .axi_awready_i(awready),
    .axi_wvalid_o(wvalid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wready_i(wready), .axi_bvalid_i(bvalid), .axi_bresp_i(bresp), .axi_bready_o(bready),
    .axi_arvalid_o(arvalid), .axi_araddr_o(araddr), .axi_arlen_o(arlen),
    .axi_arburst_o(arburst), .axi_arready_i(arready),
    .axi_rvalid_i(rvalid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rready_o(rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state
  logic [31:0] mem [logic [31:0]];
  bit          stall_en;
  logic [31:0] flip_addr;
  int          bresp_err_idx, b_count;
  int          wr_beats, rd_beats, viol;
  logic [31:0] w_base, r_base;
  int          w_beat, r_beat, r_left;
  bit          b_pend, b_fire, r_fire;
  bit          p_aw_stall, p_w_stall, p_ar_stall;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic        p_wlast;

  function automatic bit pick_ready();
    return !stall_en || ($urandom_range(0, 2) == 0);
  endfunction

  // Handshakes are decided on the falling edge and take effect on the next rising edge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    w_beat = 0; r_left = 0; r_beat = 0; b_pend = 0; b_fire = 0; r_fire = 0;
    p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0; p_wlast = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; w_base = 0; r_base = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rlast = 0; w_beat = 0; r_left = 0; r_beat = 0;
        b_pend = 0; b_fire = 0; r_fire = 0; p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0;
        continue;
      end
      if (p_aw_stall && (!awvalid || awaddr !== p_awaddr)) viol++;
      if (p_w_stall && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) viol++;
      if (p_ar_stall && (!arvalid || araddr !== p_araddr)) viol++;
      if (awvalid && wvalid) viol++;
      // B channel
      if (b_fire) begin bvalid = 0; bresp = 0; b_fire = 0; end
      if (b_pend && !bvalid) begin
        bvalid = 1;
        bresp  = (b_count == bresp_err_idx) ? 2'b10 : 2'b00;
        b_count++;
        b_pend = 0;
      end
      if (bvalid && bready) b_fire = 1;
      // R channel
      if (r_fire) begin r_beat++; r_left--; rd_beats++; r_fire = 0; end
      rvalid = 0; rlast = 0;
      if (r_left > 0 && pick_ready()) begin
        logic [31:0] a;
        a = r_base + 32'(4 * r_beat);
        rvalid = 1;
        rdata  = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
        if (a == flip_addr) rdata = rdata ^ 32'h1;
        rlast  = (r_left == 1);
        if (rready) r_fire = 1;
      end
      // AW / W / AR
      awready = awvalid && pick_ready();
      if (awvalid && awready) begin w_base = awaddr; w_beat = 0; end
      wready = wvalid && pick_ready();
      if (wvalid && wready) begin
        mem[w_base + 32'(4 * w_beat)] = wdata;
        if (wlast !== (w_beat == 15)) viol++;
        w_beat++; wr_beats++;
        if (w_beat == 16) b_pend = 1;
      end
      arready = arvalid && pick_ready();
      if (arvalid && arready) begin
        r_base = araddr; r_beat = 0; r_left = 16;
        if (wr_beats < NB * 16) viol++;
      end
      p_aw_stall = awvalid && !awready; p_awaddr = awaddr;
      p_w_stall  = wvalid && !wready;   p_wdata  = wdata; p_wlast = wlast;
      p_ar_stall = arvalid && !arready; p_araddr = araddr;
    end
  end

  // Reference: write-phase B errors precede read-phase data errors.
  function automatic void model(input logic [31:0] flip, input int bidx,
                                output int ecnt, output logic [31:0] eaddr);
    ecnt = 0; eaddr = 0;
    for (int n = 0; n < NB; n++)
      if (n == bidx) begin
        if (ecnt == 0) eaddr = BASE + 32'(64 * n);
        ecnt++;
      end
    for (int n = 0; n < NB; n++)
      for (int k = 0; k < 16; k++)
        if (BASE + 32'(64 * n + 4 * k) == flip) begin
          if (ecnt == 0) eaddr = flip;
          ecnt++;
        end
  endfunction

  function automatic int mem_bad(input logic [31:0] s);
    int bad = 0;
    for (int i = 0; i < NB * 16; i++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * i);
      if (!mem.exists(a) || mem[a] !== (a ^ s)) bad++;
    end
    return bad;
  endfunction

  task automatic run_pass(input logic [31:0] s, input bit inject_start,
                          output int done_cycles, output bit timed_out,
                          output logic busy0, output logic pass0, output logic [15:0] err0);
    wr_beats = 0; rd_beats = 0; viol = 0; b_count = 0; mem.delete();
    @(negedge clk); #2; seed = s; start = 1;
    @(negedge clk); #2; start = 0; seed = $urandom;
    busy0 = busy; pass0 = pass; err0 = err_count;
    done_cycles = 0; timed_out = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #2;
      if (inject_start && i == 20) start = 1;
      if (inject_start && i == 21) start = 0;
      if (done) begin done_cycles++; timed_out = 0; end
      else if (done_cycles > 0) break;
    end
  endtask

  task automatic check_pass(input string name, input logic [31:0] s, input logic [31:0] flip,
                            input int bidx, input bit inject);
    int dc, ecnt; bit to; logic b0, p0; logic [15:0] e0; logic [31:0] eaddr;
    flip_addr = flip; bresp_err_idx = bidx;
    run_pass(s, inject, dc, to, b0, p0, e0);
    model(flip, bidx, ecnt, eaddr);
    n_tests++; if (to) begin n_fail++; $display("FAIL %s timeout: no done_o within budget", name); end
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL %s done width: got %0d want 1", name, dc); end
    n_tests++; if (b0 !== 1'b1 || p0 !== 1'b0 || e0 !== 16'd0) begin
      n_fail++; $display("FAIL %s after start busy/pass/err: got %b/%b/%0d want 1/0/0", name, b0, p0, e0);
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy at end: got %b want 0", name, busy); end
    n_tests++; if (wr_beats != NB * 16 || rd_beats != NB * 16) begin
      n_fail++; $display("FAIL %s beats: got %0d/%0d want %0d/%0d", name, wr_beats, rd_beats, NB * 16, NB * 16);
    end
    n_tests++; if (err_count !== 16'(ecnt)) begin
      n_fail++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, ecnt);
    end
    n_tests++; if (err_addr !== eaddr) begin
      n_fail++; $display("FAIL %s err_addr: got %h want %h", name, err_addr, eaddr);
    end
    n_tests++; if (pass !== (ecnt == 0)) begin
      n_fail++; $display("FAIL %s pass: got %b want %b", name, pass, ecnt == 0);
    end
    n_tests++; if (mem_bad(s) != 0) begin
      n_fail++; $display("FAIL %s write data: got %0d bad words want 0", name, mem_bad(s));
    end
    n_tests++; if (viol != 0) begin
      n_fail++; $display("FAIL %s protocol: got %0d violations want 0", name, viol);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    n_tests++; if ({awvalid, wvalid, bready, arvalid, rready, busy, done, pass} !== 8'd0) begin
      n_fail++; $display("FAIL reset flags: got %b want 0", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass});
    end
    n_tests++; if (err_count !== 16'd0 || err_addr !== 32'd0 || awaddr !== 32'd0 || wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset regs: got %h %h %h %h want 0", err_count, err_addr, awaddr, wdata);
    end
    n_tests++; if ({awlen, awburst, wstrb, arlen, arburst} !== {8'd15, 2'b01, 4'hF, 8'd15, 2'b01}) begin
      n_fail++; $display("FAIL reset constants: got %h want %h", {awlen, awburst, wstrb, arlen, arburst},
                         {8'd15, 2'b01, 4'hF, 8'd15, 2'b01});
    end
    @(negedge clk); #2; rst = 0;
  endtask

  task automatic test_ideal();
    stall_en = 0;
    check_pass("ideal", 32'hA5A5_A5A5, NO_FLIP, -1, 0);
  endtask

  task automatic test_bitflip();
    stall_en = 0;
    check_pass("bitflip", $urandom, 32'h48, -1, 0);
  endtask

  task automatic test_stalls();
    stall_en = 1;
    check_pass("stall_a5", 32'hA5A5_A5A5, NO_FLIP, -1, 0);
    for (int i = 0; i < 2; i++) check_pass("stall_rand", $urandom, NO_FLIP, -1, 0);
    check_pass("stall_flip", $urandom, BASE + 32'(4 * $urandom_range(0, NB * 16 - 1)), -1, 0);
    stall_en = 0;
  endtask

  task automatic test_bresp();
    stall_en = 0;
    check_pass("bresp", $urandom, NO_FLIP, 1, 0);
    check_pass("bresp_and_flip", $urandom, 32'h4, 1, 0);
  endtask

  task automatic test_back_to_back();
    stall_en = 1;
    check_pass("b2b_fail", $urandom, 32'h3C, -1, 0);
    check_pass("b2b_ignored_start", $urandom, NO_FLIP, -1, 1);
    stall_en = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bit found = 0;
    s = $urandom; stall_en = 1; flip_addr = NO_FLIP; bresp_err_idx = -1;
    @(negedge clk); #2; seed = s; start = 1;
    @(negedge clk); #2; start = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk); #2;
      if (wvalid && wdata === ((BASE + 32'd28) ^ s)) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL reset_mid reach beat 7: got none want wvalid at beat 7"); end
    rst = 1; #1;
    n_tests++; if ({awvalid, wvalid, wlast, bready, arvalid, rready, busy, done} !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid valids: got %b want 0", {awvalid, wvalid, wlast, bready, arvalid, rready, busy, done});
    end
    @(negedge clk); #2; rst = 0;
    check_pass("after_reset", $urandom, NO_FLIP, -1, 0);
    stall_en = 0;
  endtask

  initial begin
    rst = 1; start = 0; seed = 0; stall_en = 0; flip_addr = NO_FLIP;
    bresp_err_idx = -1; b_count = 0; wr_beats = 0; rd_beats = 0; viol = 0;
    test_reset();
    test_ideal();
    test_bitflip();
    test_stalls();
    test_bresp();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
